// File: rtl/pulse_width_decoder.sv
// pulse_width_decoder: decodes pulse-width-encoded serial frames (short pulse = 0, long pulse = 1)
module pulse_width_decoder #(
  parameter int NBITS     = 8,
  parameter int T0_MIN    = 2,
  parameter int T0_MAX    = 4,
  parameter int T1_MIN    = 6,
  parameter int T1_MAX    = 10,
  parameter int T_GAP_MAX = 8,
  parameter int CW        = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             din,
  output logic [NBITS-1:0] data_out,
  output logic             data_valid,
  output logic             frame_err,
  output logic             busy
);
  localparam int BW = $clog2(NBITS + 1);
  // The first high (or low) cycle is the one that causes the state change, so a
  // timer value of t means t+1 cycles of the current level have been seen.
  localparam logic [CW-1:0] C_T0_LO  = CW'(T0_MIN - 1);
  localparam logic [CW-1:0] C_T0_HI  = CW'(T0_MAX - 1);
  localparam logic [CW-1:0] C_T1_LO  = CW'(T1_MIN - 1);
  localparam logic [CW-1:0] C_T1_HI  = CW'(T1_MAX - 1);
  localparam logic [CW-1:0] C_GAP_HI = CW'(T_GAP_MAX - 1);
  localparam logic [CW-1:0] C_GAP    = CW'(T_GAP_MAX);
  localparam logic [BW-1:0] C_LAST   = BW'(NBITS - 1);
  typedef enum logic [1:0] {IDLE, HIGH, LOW, ERR} state_t;
  state_t           r_state;
  logic             r_s1, r_s2;
  logic [CW-1:0]    r_t;
  logic [BW-1:0]    r_bit_cnt;
  logic [NBITS-1:0] r_shift;
  logic             w_din_s, w_is0, w_is1, w_err;
  logic [CW-1:0]    w_t_inc;
  logic [NBITS-1:0] w_shift;
  assign w_din_s = r_s2;
  assign w_t_inc = &r_t ? r_t : r_t + 1'b1;
  assign w_is0   = r_t >= C_T0_LO && r_t <= C_T0_HI;
  assign w_is1   = r_t >= C_T1_LO && r_t <= C_T1_HI;
  // Bits enter at the top and move down, so after NBITS bits the first one sits in the LSB.
  assign w_shift = {w_is1, r_shift[NBITS-1:1]};
  // A pulse reaching T1_MAX+1 cycles with din_s still high is the same timer value
  // as the largest legal bit-1 width, just seen with din_s high instead of low.
  assign w_err   = (r_state == HIGH && (w_din_s ? r_t == C_T1_HI : !(w_is0 || w_is1))) ||
                   (r_state == LOW && !w_din_s && r_t == C_GAP_HI);
  // Synchronizer, decode FSM, shared timer and registered strobes.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1       <= 1'b0;
      r_s2       <= 1'b0;
      r_state    <= IDLE;
      r_t        <= '0;
      r_bit_cnt  <= '0;
      r_shift    <= '0;
      data_out   <= '0;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      r_s1       <= din;
      r_s2       <= r_s1;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
      if (w_err) begin
        r_state   <= ERR;
        r_t       <= '0;
        r_bit_cnt <= '0;
        r_shift   <= '0;
        frame_err <= 1'b1;
        busy      <= 1'b1;
      end else begin
        case (r_state)
          IDLE: begin
            if (w_din_s) begin
              r_state   <= HIGH;
              r_t       <= '0;
              r_bit_cnt <= '0;
              busy      <= 1'b1;
            end else r_t <= w_t_inc;
          end
          HIGH: begin
            if (w_din_s) r_t <= w_t_inc;
            else begin
              r_t     <= '0;
              r_shift <= w_shift;
              if (r_bit_cnt == C_LAST) begin
                r_state    <= IDLE;
                r_bit_cnt  <= '0;
                data_out   <= w_shift;
                data_valid <= 1'b1;
                busy       <= 1'b0;
              end else begin
                r_state   <= LOW;
                r_bit_cnt <= r_bit_cnt + 1'b1;
              end
            end
          end
          LOW: begin
            if (w_din_s) begin
              r_state <= HIGH;
              r_t     <= '0;
            end else r_t <= w_t_inc;
          end
          ERR: begin
            if (w_din_s) r_t <= '0;
            else if (r_t == C_GAP) begin
              r_state <= IDLE;
              r_t     <= '0;
              busy    <= 1'b0;
            end else r_t <= w_t_inc;
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end
endmodule
